// File: rtl/mult_accum_pkg.sv
// -----------------------------------------------------------------------------
// mult_accum_pkg
// Shared definitions for the Q16.16 multiply-accumulate datapath:
//   - Q16.16 fixed-point constants
//   - state encoding for the accumulator controller
// No ports (package).
// -----------------------------------------------------------------------------
package mult_accum_pkg;

  // Q16.16 fixed-point format
  localparam int          FRAC_BITS = 16;
  localparam logic [31:0] FIX_ONE   = 32'h0001_0000;
  localparam logic [31:0] FIX_MAX   = 32'hFFFF_FFFF;

  // Controller state encoding
  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] ACCUM_ENC = 2'd1;
  localparam logic [1:0] FINAL_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,
    ACCUM = ACCUM_ENC,
    FINAL = FINAL_ENC
  } state_t;

endpackage : mult_accum_pkg

// File: rtl/mult_accum_sat_trunc.sv
// -----------------------------------------------------------------------------
// sat_trunc
// Combinational saturating truncation of an unsigned ACC_W-bit Q(ACC_W-16).16
// value down to unsigned Q16.16. Any set bit above bit 31 means the value does
// not fit, in which case the output clamps to FIX_MAX.
// Ports:
//   i_acc  in   ACC_W  wide unsigned value (low 16 bits are fraction)
//   o_sum  out  32     saturated Q16.16 result
//   o_sat  out  1      high when saturation occurred
// -----------------------------------------------------------------------------
module sat_trunc
  import mult_accum_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] i_acc,
  output logic [31:0]      o_sum,
  output logic             o_sat
);

  logic w_sat;

  // "Greater than 32'hFFFF_FFFF" is the same as any upper bit being set.
  assign w_sat = |i_acc[ACC_W-1:32];
  assign o_sat = w_sat;
  assign o_sum = w_sat ? FIX_MAX : i_acc[31:0];

endmodule : sat_trunc

// File: rtl/mult_accum.sv
// -----------------------------------------------------------------------------
// mult_accum
// Accumulates a programmed number of unsigned Q16.16 products (streamed in
// over a valid/ready handshake) into a wide accumulator, then reports the
// saturated Q16.16 sum with a one-cycle done pulse.
// Ports:
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-high reset
//   start       in   1      begin a new accumulation (sampled only in IDLE)
//   len         in   LEN_W  number of products to accumulate (sampled with start)
//   prod_valid  in   1      prod carries a valid product
//   prod        in   32     unsigned Q16.16 product
//   prod_ready  out  1      product accepted this cycle when prod_valid is high
//   busy        out  1      high in any state other than IDLE
//   done        out  1      one-cycle pulse; sum/overflow valid
//   sum         out  32     saturated unsigned Q16.16 result (held until next run ends)
//   overflow    out  1      accumulator exceeded 32'hFFFF_FFFF in the last run
// -----------------------------------------------------------------------------
module mult_accum
  import mult_accum_pkg::*;
#(
  parameter int ACC_W = 40,  // must be >= 33; with LEN_W = 8 no internal wrap
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             prod_valid,
  input  logic [31:0]      prod,
  output logic             prod_ready,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sum,
  output logic             overflow
);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic [31:0]      r_sum;
  logic             r_ovf;
  logic             r_done;

  logic             w_ready;
  logic [LEN_W-1:0] w_cnt_next;
  logic [ACC_W-1:0] w_prod_ext;
  logic [31:0]      w_sat_sum;
  logic             w_sat;

  // Ready depends on state only, so a source may sample it before deciding
  // to raise prod_valid without creating a combinational loop.
  assign w_ready    = (r_state == ACCUM);
  assign w_cnt_next = r_cnt + LEN_W'(1);
  assign w_prod_ext = {{(ACC_W-32){1'b0}}, prod};

  sat_trunc #(
    .ACC_W (ACC_W)
  ) u_sat_trunc (
    .i_acc (r_acc),
    .o_sum (w_sat_sum),
    .o_sat (w_sat)
  );

  // NOTE: every register here is written with <= so all state updates see
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;  // pulse: only the FINAL branch raises it
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len   <= len;
            // A zero-length job skips straight to reporting an empty sum.
            r_state <= (len == '0) ? FINAL : ACCUM;
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            r_acc <= r_acc + w_prod_ext;
            r_cnt <= w_cnt_next;
            if (w_cnt_next == r_len) begin
              r_state <= FINAL;
            end
          end
        end
        FINAL: begin
          r_sum   <= w_sat_sum;
          r_ovf   <= w_sat;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign prod_ready = w_ready;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign sum        = r_sum;
  assign overflow   = r_ovf;

endmodule : mult_accum
